// File: rtl/urng_taus.sv
// Dual taus88 uniform RNG for a Box-Muller stage: u0 (48b) = {A.out, B.out[31:16]}, u1 (16b) = B.out[15:0].
// Latency: first sample one cycle after WARMUP steps; then one sample per cycle. Backpressure: out_valid/out_ready, sample held until accepted.
// Optional: define URNG_SEED_FIX_EN to force degenerate seed words to usable values on reseed.
module urng_taus #(
   parameter int unsigned WARMUP = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        seed_wr,
   input  logic [31:0] seed_data,
   input  logic        out_ready,
   output logic [47:0] u0,
   output logic [15:0] u1,
   output logic        out_valid,
   output logic        busy
);

   typedef enum logic {WARMUP_ST, RUN_ST} state_t;

   localparam logic [31:0] A1_DEF = 32'h12345678;
   localparam logic [31:0] A2_DEF = 32'h9ABCDEF0;
   localparam logic [31:0] A3_DEF = 32'h0F1E2D3C;
   localparam logic [31:0] B1_DEF = 32'h4B5A6978;
   localparam logic [31:0] B2_DEF = 32'h87654321;
   localparam logic [31:0] B3_DEF = 32'hDEADBEEF;
   localparam logic [7:0]  WU_LAST = 8'(WARMUP - 1);

   state_t      state;
   logic [7:0]  wcnt;
   logic [2:0]  cnt;
   logic [31:0] shadow [0:4];

   logic [31:0] a1, a2, a3, b1, b2, b3;
   logic [31:0] a1_n, a2_n, a3_n, b1_n, b2_n, b3_n;
   logic [31:0] a_out, b_out;
   logic        seed_last;
   logic        take;

   function automatic logic [31:0] step1(input logic [31:0] s);
      step1 = ((s & 32'hFFFFFFFE) << 12) ^ (((s << 13) ^ s) >> 19);
   endfunction

   function automatic logic [31:0] step2(input logic [31:0] s);
      step2 = ((s & 32'hFFFFFFF8) << 4) ^ (((s << 2) ^ s) >> 25);
   endfunction

   function automatic logic [31:0] step3(input logic [31:0] s);
      step3 = ((s & 32'hFFFFFFF0) << 17) ^ (((s << 3) ^ s) >> 11);
   endfunction

   // Each component needs some bit above its masked-off LSBs set, else it collapses to zero.
`ifdef URNG_SEED_FIX_EN
   function automatic logic [31:0] fix1(input logic [31:0] w);
      fix1 = (w < 32'd2) ? (w | 32'd2) : w;
   endfunction
   function automatic logic [31:0] fix2(input logic [31:0] w);
      fix2 = (w < 32'd8) ? (w | 32'd8) : w;
   endfunction
   function automatic logic [31:0] fix3(input logic [31:0] w);
      fix3 = (w < 32'd16) ? (w | 32'd16) : w;
   endfunction
`else
   function automatic logic [31:0] fix1(input logic [31:0] w);
      fix1 = w;
   endfunction
   function automatic logic [31:0] fix2(input logic [31:0] w);
      fix2 = w;
   endfunction
   function automatic logic [31:0] fix3(input logic [31:0] w);
      fix3 = w;
   endfunction
`endif

   always_comb begin
      a1_n  = step1(a1);
      a2_n  = step2(a2);
      a3_n  = step3(a3);
      b1_n  = step1(b1);
      b2_n  = step2(b2);
      b3_n  = step3(b3);
      a_out = a1_n ^ a2_n ^ a3_n;
      b_out = b1_n ^ b2_n ^ b3_n;
   end

   assign seed_last = seed_wr && (cnt == 3'd5);
   assign take      = (state == RUN_ST) && (!out_valid || out_ready);
   assign busy      = (state == WARMUP_ST) || (cnt != 3'd0);

   // Shadow needs no reset: cnt restarts at 0 and every word is rewritten before use.
   always_ff @(posedge clk) begin
      if (seed_wr && (cnt != 3'd5)) begin
         shadow[cnt] <= seed_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= WARMUP_ST;
         wcnt      <= 8'd0;
         cnt       <= 3'd0;
         a1        <= A1_DEF;
         a2        <= A2_DEF;
         a3        <= A3_DEF;
         b1        <= B1_DEF;
         b2        <= B2_DEF;
         b3        <= B3_DEF;
         u0        <= 48'd0;
         u1        <= 16'd0;
         out_valid <= 1'b0;
      end else begin
         if (seed_wr) begin
            cnt <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
         end

         if (seed_last) begin
            // Reseed wins over stepping; a sample accepted this edge is the last of the old sequence.
            a1        <= fix1(shadow[0]);
            a2        <= fix2(shadow[1]);
            a3        <= fix3(shadow[2]);
            b1        <= fix1(shadow[3]);
            b2        <= fix2(shadow[4]);
            b3        <= fix3(seed_data);
            out_valid <= 1'b0;
            state     <= WARMUP_ST;
            wcnt      <= 8'd0;
         end else begin
            case (state)
               WARMUP_ST: begin
                  a1 <= a1_n;
                  a2 <= a2_n;
                  a3 <= a3_n;
                  b1 <= b1_n;
                  b2 <= b2_n;
                  b3 <= b3_n;
                  if (wcnt == WU_LAST) begin
                     state <= RUN_ST;
                     wcnt  <= 8'd0;
                  end else begin
                     wcnt <= wcnt + 8'd1;
                  end
               end
               RUN_ST: begin
                  if (take) begin
                     a1        <= a1_n;
                     a2        <= a2_n;
                     a3        <= a3_n;
                     b1        <= b1_n;
                     b2        <= b2_n;
                     b3        <= b3_n;
                     u0        <= {a_out, b_out[31:16]};
                     u1        <= b_out[15:0];
                     out_valid <= 1'b1;
                  end
               end
               default: state <= WARMUP_ST;
            endcase
         end
      end
   end

endmodule

// File: doc/urng_taus.md
URNG_TAUS -- requirements
Module: urng_taus

Interface
REQ-001 SHALL have parameter WARMUP, default 16, number of generator steps discarded after reset or reseed (range 1..255).
REQ-002 SHALL have input clk, 1 bit, rising-edge clock.
REQ-003 SHALL have input reset, 1 bit, synchronous, active-high; clock clk.
REQ-004 SHALL have input seed_wr, 1 bit, seed-word write strobe.
REQ-005 SHALL have input seed_data, 32 bits, seed word, written in order A.s1, A.s2, A.s3, B.s1, B.s2, B.s3.
REQ-006 SHALL have input out_ready, 1 bit, consumer (Box-Muller stage) accepts the current sample.
REQ-007 SHALL have output u0, 48 bits, registered uniform sample feeding the logarithm/sqrt path.
REQ-008 SHALL have output u1, 16 bits, registered uniform sample feeding the sin/cos path.
REQ-009 SHALL have output out_valid, 1 bit, u0/u1 hold a fresh sample.
REQ-010 SHALL have output busy, 1 bit, high while in WARMUP or while a seed load is partially written.

Function
REQ-011 SHALL contain two independent taus88 combined Tausworthe generators, A and B, each with three 32-bit states s1,s2,s3.
REQ-012 One step SHALL update: s1'=((s1&FFFFFFFE)<<12)^(((s1<<13)^s1)>>19); s2'=((s2&FFFFFFF8)<<4)^(((s2<<2)^s2)>>25); s3'=((s3&FFFFFFF0)<<17)^(((s3<<3)^s3)>>11); out=s1'^s2'^s3' (all unsigned 32-bit, logical shifts).
REQ-013 Sample mapping SHALL be u0={A.out[31:0], B.out[31:16]}, u1=B.out[15:0].
REQ-014 FSM states SHALL be WARMUP and RUN; reset and a completed reseed enter WARMUP with warm-up counter cleared.
REQ-015 In WARMUP both generators SHALL step every cycle; after exactly WARMUP steps the FSM SHALL enter RUN; outputs are not loaded and out_valid stays 0.
REQ-016 In RUN, when out_valid==0 or out_ready==1, generators SHALL step once and u0/u1 SHALL load the new sample with out_valid=1 on the next cycle; otherwise state and outputs SHALL hold.
REQ-017 Samples SHALL never be dropped or duplicated: with out_valid=1 and out_ready=0, u0/u1 stay stable until accepted.
REQ-018 Seed load: a 3-bit word counter SHALL store seed_data into shadow register [cnt] on each seed_wr; on the sixth word the shadow SHALL be copied into A/B states, cnt SHALL return to 0, out_valid SHALL clear and the FSM SHALL enter WARMUP, all in the same edge.
REQ-019 Seed words 1-5 SHALL not disturb generation; a partial load SHALL be discarded only by reset.
REQ-020 seed_wr coincident with an output handshake SHALL complete the handshake first; on the sixth word the reseed takes priority and the accepted sample is the last of the old sequence.

Reset
REQ-021 Reset SHALL set u0=0, u1=0, out_valid=0, busy=1, cnt=0, FSM=WARMUP, warm-up counter=0.
REQ-022 Reset SHALL load default seeds A=(12345678, 9ABCDEF0, 0F1E2D3C), B=(4B5A6978, 87654321, DEADBEEF) (hex).
REQ-023 Reset mid-seed-load or mid-handshake SHALL abandon it with no residual effect.

Configuration
REQ-024 Macro URNG_SEED_FIX_EN defined: on reseed, any s1<2, s2<8, s3<16 SHALL be replaced by word|2, word|8, word|16 respectively, guaranteeing a non-degenerate sequence.
REQ-025 Macro URNG_SEED_FIX_EN undefined: seed words SHALL load verbatim; degenerate seeds (e.g. all zero) yield a degenerate sequence by design.

Verification
REQ-026 Reset released at cycle 0, out_ready=1, WARMUP=16 -> out_valid first high at cycle 17, u0/u1 equal the golden taus88 C model output at step 17, then a new sample every cycle.
REQ-027 out_ready held 0 for 10 cycles in RUN -> u0/u1/out_valid constant; after out_ready=1 the sequence resumes with the next model step, none skipped.
REQ-028 Six seed writes of 00000001, 00000003, 00000007, same for B -> with URNG_SEED_FIX_EN states become 3, B, 17 and output matches model; without the macro states load verbatim.
REQ-029 All-zero reseed without URNG_SEED_FIX_EN -> after warm-up u0=0, u1=0 every sample.
REQ-030 Reset asserted after three seed words -> cnt=0, default seeds restored, next full six-word load applies correctly.
